i2c_bus_monitor: RTL

I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

---
 rtl/i2c_mon_pkg.sv | 15 +
 rtl/i2c_mon_filter.sv | 44 ++++
 rtl/i2c_bus_monitor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_mon_pkg.sv
// Shared FSM state type and protocol constants for the I2C bus monitor.
package i2c_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } mon_state_e;

  localparam int   BITS_PER_BYTE = 8;
  localparam logic ACK_LVL       = 1'b0;
  localparam logic NACK_LVL      = 1'b1;

endpackage

// File: rtl/i2c_mon_filter.sv
// Synchroniser chain plus persistence glitch filter for one raw bus line.
// All flops preset to 1 so an idle bus is seen right out of reset.
module i2c_mon_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q;
  logic [3:0]             cnt_q;
  logic                   samp;

  assign samp   = sync_q[SYNC_STAGES-1];
  assign filt_o = filt_q;

  // cnt_q counts consecutive samples that disagree with the filtered level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      if (samp != filt_q) begin
        if (cnt_q == CNT_MAX) begin
          filt_q <= samp;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: START/STOP detection, byte capture, error flagging.
// Event counters are built only when I2C_MON_COUNTERS_EN is defined.
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             scl_i,
  input  logic             sda_i,
  input  logic             clr_cnt,
  output logic             bus_busy,
  output logic             start_pulse,
  output logic             rstart_pulse,
  output logic             stop_pulse,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_is_addr,
  output logic             rw_bit,
  output logic             ack_bit,
  output logic             err_pulse,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] stop_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic scl_f, sda_f;
  logic scl_p_q, sda_p_q;

  i2c_mon_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i (pclk),
    .rst_ni(presetn),
    .raw_i (scl_i),
    .filt_o(scl_f)
  );

  i2c_mon_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i (pclk),
    .rst_ni(presetn),
    .raw_i (sda_i),
    .filt_o(sda_f)
  );

  logic start_det, stop_det, scl_rise, scl_fall;

  assign start_det = scl_f &  sda_p_q & ~sda_f;
  assign stop_det  = scl_f & ~sda_p_q &  sda_f;
  assign scl_rise  =  scl_f & ~scl_p_q;
  assign scl_fall  = ~scl_f &  scl_p_q;

  mon_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       is_addr_q, is_addr_d;
  logic       armed_q, armed_d;
  logic       first_hi_q, first_hi_d;
  logic       busy_q, busy_d;
  logic       start_q, start_d;
  logic       rstart_q, rstart_d;
  logic       stop_q, stop_d;
  logic       bv_q, bv_d;
  logic       err_q, err_d;
  logic [7:0] data_q, data_d;
  logic       isaddr_q, isaddr_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       mid_byte;

  // A START/STOP inside the high phase of the first bit is the setup clock of
  // that START/STOP itself, not a truncated byte.
  assign mid_byte = (bit_cnt_q != 4'd0) && !(first_hi_q && (bit_cnt_q == 4'd1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      is_addr_q  <= 1'b0;
      armed_q    <= 1'b0;
      first_hi_q <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      rstart_q   <= 1'b0;
      stop_q     <= 1'b0;
      bv_q       <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= 8'h00;
      isaddr_q   <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= NACK_LVL;
    end else begin
      scl_p_q    <= scl_f;
      sda_p_q    <= sda_f;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      is_addr_q  <= is_addr_d;
      armed_q    <= armed_d;
      first_hi_q <= first_hi_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      rstart_q   <= rstart_d;
      stop_q     <= stop_d;
      bv_q       <= bv_d;
      err_q      <= err_d;
      data_q     <= data_d;
      isaddr_q   <= isaddr_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
    end
  end

  // armed_q stays low after reset until a START, so leftovers of an interrupted
  // transfer raise no events.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    is_addr_d  = is_addr_q;
    armed_d    = armed_q;
    first_hi_d = first_hi_q;
    data_d     = data_q;
    isaddr_d   = isaddr_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    start_d    = 1'b0;
    rstart_d   = 1'b0;
    stop_d     = 1'b0;
    bv_d       = 1'b0;
    err_d      = 1'b0;

    if (start_det) begin
      armed_d    = 1'b1;
      is_addr_d  = 1'b1;
      bit_cnt_d  = '0;
      first_hi_d = 1'b0;
      state_d    = ADDR;
      err_d      = mid_byte;
      if (state_q == IDLE) start_d  = 1'b1;
      else                 rstart_d = 1'b1;
    end else if (stop_det) begin
      stop_d     = armed_q;
      err_d      = armed_q & mid_byte;
      bit_cnt_d  = '0;
      first_hi_d = 1'b0;
      state_d    = IDLE;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, DATA: begin
          shift_d    = {shift_q[6:0], sda_f};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          first_hi_d = (bit_cnt_q == 4'd0);
          if (bit_cnt_q == 4'(BITS_PER_BYTE - 1)) state_d = ACK;
        end
        ACK: begin
          ack_d     = (sda_f == ACK_LVL) ? ACK_LVL : NACK_LVL;
          bv_d      = 1'b1;
          data_d    = shift_q;
          isaddr_d  = is_addr_q;
          if (is_addr_q) rw_d = shift_q[0];
          is_addr_d = 1'b0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        default: err_d = armed_q;
      endcase
    end else if (scl_fall) begin
      first_hi_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus_busy     = busy_q;
  assign start_pulse  = start_q;
  assign rstart_pulse = rstart_q;
  assign stop_pulse   = stop_q;
  assign byte_valid   = bv_q;
  assign byte_data    = data_q;
  assign byte_is_addr = isaddr_q;
  assign rw_bit       = rw_q;
  assign ack_bit      = ack_q;
  assign err_pulse    = err_q;

`ifdef I2C_MON_COUNTERS_EN
  logic [CNT_W-1:0] start_cnt_q, stop_cnt_q, byte_cnt_q, err_cnt_q;

  // Counters step on the same edge as their pulse and hold at all-ones.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      start_cnt_q <= '0;
      stop_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else if (clr_cnt) begin
      start_cnt_q <= '0;
      stop_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if ((start_d | rstart_d) && (start_cnt_q != '1)) start_cnt_q <= start_cnt_q + CNT_W'(1);
      if (stop_d && (stop_cnt_q != '1))                stop_cnt_q  <= stop_cnt_q + CNT_W'(1);
      if (bv_d && (byte_cnt_q != '1))                  byte_cnt_q  <= byte_cnt_q + CNT_W'(1);
      if (err_d && (err_cnt_q != '1))                  err_cnt_q   <= err_cnt_q + CNT_W'(1);
    end
  end

  assign start_cnt = start_cnt_q;
  assign stop_cnt  = stop_cnt_q;
  assign byte_cnt  = byte_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign start_cnt  = '0;
  assign stop_cnt   = '0;
  assign byte_cnt   = '0;
  assign err_cnt    = '0;
`endif

endmodule
